// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-speed tester sequencer.
// Arms a pseudo-random wait, lights the go LED, times the player's press in
// 1 ms ticks as a 4-digit BCD value and flags presses made before the LED.
// Optional feature macro: REACTION_BEST_EN (keeps the best non-overflowed result).
`timescale 1ns/1ps

module reaction_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int MIN_DLY_MS = 1000,
  parameter int RAND_BITS  = 11
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        press,
  output logic        LED,
  output logic [15:0] result_bcd,
  output logic        result_valid,
  output logic        false_start,
  output logic        overflow,
  output logic [2:0]  state,
  output logic [15:0] best_bcd
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_DONE = 3'd3,
    S_FOUL = 3'd4
  } state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(MIN_DLY_MS + (1 << RAND_BITS) + 1);

  state_t        st;
  logic          s1, s2, s3, p_evt;
  logic [15:0]   lfsr;
  logic [PW-1:0] presc;
  logic          tick;
  logic          restart;
  logic [DW-1:0] dly;
  logic [DW-1:0] dly_load;
  logic [15:0]   bcd;

  // Decimal increment of a 4-digit BCD value with per-digit carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Press synchronizer and rising-edge detector; p_evt is a 1-cycle pulse.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      p_evt <= 1'b0;
    end else begin
      s1    <= press;
      s2    <= s1;
      s3    <= s2;
      p_evt <= s2 & ~s3;
    end
  end

  // Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign dly_load = DW'(MIN_DLY_MS) + DW'(lfsr[RAND_BITS-1:0]);

  // Prescaler restarts whenever the FSM is about to enter WAIT or GO.
  always_comb begin
    restart = 1'b0;
    case (st)
      S_IDLE:  restart = p_evt;
      S_WAIT:  restart = ~p_evt & tick & (dly == DW'(1));
      S_DONE:  restart = p_evt;
      default: restart = 1'b0;
    endcase
  end

  // 1 ms tick prescaler.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
    end else if (restart || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Round sequencer with registered status outputs.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      st           <= S_IDLE;
      dly          <= '0;
      bcd          <= '0;
      overflow     <= 1'b0;
      LED          <= 1'b0;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
    end else begin
      case (st)
        S_IDLE: begin
          if (p_evt) begin
            st       <= S_WAIT;
            dly      <= dly_load;
            bcd      <= '0;
            overflow <= 1'b0;
          end
        end
        S_WAIT: begin
          if (p_evt) begin
            st          <= S_FOUL;
            false_start <= 1'b1;
          end else if (tick) begin
            if (dly == DW'(1)) begin
              st  <= S_GO;
              LED <= 1'b1;
            end else begin
              dly <= dly - DW'(1);
            end
          end
        end
        S_GO: begin
          if (p_evt) begin
            st           <= S_DONE;
            LED          <= 1'b0;
            result_valid <= 1'b1;
          end else if (tick) begin
            if (bcd == 16'h9999) begin
              st           <= S_DONE;
              LED          <= 1'b0;
              result_valid <= 1'b1;
              overflow     <= 1'b1;
            end else begin
              bcd <= bcd_inc(bcd);
            end
          end
        end
        S_DONE: begin
          if (p_evt) begin
            st           <= S_WAIT;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            dly          <= dly_load;
            bcd          <= '0;
          end
        end
        S_FOUL: begin
          if (p_evt) begin
            st          <= S_IDLE;
            false_start <= 1'b0;
          end
        end
        default: begin
          st           <= S_IDLE;
          LED          <= 1'b0;
          result_valid <= 1'b0;
          false_start  <= 1'b0;
          overflow     <= 1'b0;
        end
      endcase
    end
  end

  assign state      = st;
  assign result_bcd = false_start ? '0 : bcd;

`ifdef REACTION_BEST_EN
  // Best result tracker; a press-terminated round in GO never overflows.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      best_bcd <= 16'h9999;
    end else if ((st == S_GO) && p_evt && (bcd < best_bcd)) begin
      best_bcd <= bcd;
    end
  end
`else
  assign best_bcd = '0;
`endif

endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
Sequencer for the reaction-speed tester datapath. It arms a pseudo-random wait, lights the go LED, and times the player's press in 1 ms units as a 4-digit BCD value that the 7-segment scanner displays. It also detects presses made before the LED lights (false starts). It sits between the debounced press input and the display/LED outputs inside top.

Parameters:
TICK_DIV, 100000, sysclk cycles per 1 ms tick (100 MHz sysclk); the bench overrides it to a small value.
MIN_DLY_MS, 1000, minimum wait before the LED lights, in ticks; must be >= 1.
RAND_BITS, 11, width of the random addend; actual wait = MIN_DLY_MS + lfsr[RAND_BITS-1:0] ticks.

Ports:
sysclk  in  1  system clock; all state changes on its rising edge.
reset  in  1  asynchronous, active-low reset.
press  in  1  debounced player button, active-high; held >= 1 sysclk cycle.
LED  out  1  go light; 1 only in GO.
result_bcd  out  16  4 BCD digits, [15:12] = thousands, [3:0] = units, in ms.
result_valid  out  1  1 while result_bcd holds a finished measurement (DONE).
false_start  out  1  1 in FOUL.
overflow  out  1  1 in DONE when the count saturated at 9999.
state  out  3  IDLE=0, WAIT=1, GO=2, DONE=3, FOUL=4 (for debug and display mux).
best_bcd  out  16  best (lowest) valid result; see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0.
  - lfsr=16'hACE1; prescaler=0; delay counter=0; BCD counter=0000.
- Press input path:
  - 2-flop synchronizer, then rising-edge detect producing p_evt (1 cycle).
  - p_evt is asserted 3 sysclk edges after press rises.
  - A held press produces exactly one event.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state.
- Tick:
  - Prescaler counts 0..TICK_DIV-1; tick=1 in the cycle it equals TICK_DIV-1, then it wraps to 0.
  - Prescaler is cleared in the cycle the FSM enters WAIT or GO.
- FSM (transitions take effect on the sysclk edge following the condition):
  - IDLE: on p_evt -> WAIT. Load delay = MIN_DLY_MS + lfsr[RAND_BITS-1:0]; clear BCD counter and overflow.
  - WAIT: on tick, decrement delay.
    - p_evt -> FOUL. p_evt takes priority over a coincident tick or expiry.
    - Tick with delay==1 -> GO.
  - GO: LED=1. On each tick, BCD counter increments with decimal carry per digit.
    - p_evt -> DONE; the counter freezes and does not take a coincident tick.
    - Tick with counter==9999 -> DONE with overflow=1; the counter stays 9999.
  - DONE: result_valid=1; result_bcd holds the value. p_evt -> WAIT, reloading delay and clearing the counter.
  - FOUL: false_start=1; result_bcd=0. p_evt -> IDLE.
- result_bcd mirrors the BCD counter in every state except FOUL.
- Reset asserted mid-round returns immediately to reset values, including in GO with LED lit.

Optional Feature:
- Macro: REACTION_BEST_EN.
- Defined:
  - Register best_bcd, reset value 9999.
  - On entry to DONE with overflow=0, if result < best_bcd, best_bcd updates on the same edge that enters DONE.
  - Overflowed and FOUL rounds never update it.
- Undefined: best_bcd is tied to 16'h0000 and no compare logic is built.

Test Plan:
Bench parameters: TICK_DIV=10, MIN_DLY_MS=2, RAND_BITS=2, sysclk 10 ns.
- Reset: release reset, then 20 cycles idle -> state=0, LED=0, result_bcd=0000, all flags 0.
- Normal round:
  - Stimulus: press pulse, wait until LED=1, then press again 37 ticks (370 cycles) later.
  - Required: wait lasted 2..5 ticks; state=3; result_bcd=16'h0037 (±1 for the sync latency at the tick boundary); LED=0; result_valid=1.
- False start: press, then press again 1 tick later (inside the minimum wait) -> state=4, false_start=1, LED never asserted; next press -> state=0.
- Saturation:
  - Stimulus: TICK_DIV=2; arm; never press.
  - Required: result_bcd reaches 16'h9999, then state=3, overflow=1, value stays 9999.
- Mid-round reset: assert reset while LED=1 -> LED=0 and state=0 asynchronously, before the next sysclk edge.
- REACTION_BEST_EN: rounds of 0050, 0030, 0040, then a FOUL round -> best_bcd=0030; without the macro, best_bcd=0000 throughout.
